ram_burst_ctrl: RTL

- Initiator for the team's single-port block RAM interface (en, wen, addr, datai in; datao out; 1-cycle registered read; datao forced to 0 the cycle after en=0).
- Converts a burst command (direction, start address, beat count) into RAM cycles.
- Write data arrives on a valid/ready stream. Read data leaves on a valid/ready stream with full backpressure, absorbing the RAM's fixed read latency.

---
 rtl/ram_burst_ctrl_if.sv | 42 ++++
 rtl/ram_burst_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle between a burst user and ram_burst_ctrl: command, write stream,
// read stream, status and the single-port RAM pins.
interface ram_burst_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int LWIDTH = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [LWIDTH-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DWIDTH-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              ram_en;
  logic              ram_wen;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  // master: command issuer / stream endpoints / RAM data return
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
           rd_ready, ram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

  // slave: the burst controller
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
           rd_ready, ram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the single-port block RAM: turns a (dir, addr, len)
// command into RAM cycles, with a 2-entry skid FIFO on the read path.
module ram_burst_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int LWIDTH = 9
) (
  input logic             clk,
  input logic             rst,
  ram_burst_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state;
  logic [AWIDTH-1:0]      cur_addr;
  logic [LWIDTH-1:0]      remaining;   // beats left to write / reads left to issue
  logic [LWIDTH-1:0]      pop_left;    // read beats not yet handed to the consumer
  logic [1:0][DWIDTH-1:0] fifo;
  logic                   wptr, rptr;
  logic [1:0]             cnt;
  logic                   inflight;    // a read was issued last cycle; data is on ram_rdata now
  logic [2:0]             occ;
  logic                   wr_fire, issue, pop, cmd_fire;

  assign cmd_fire = bus.cmd_valid && (state == S_IDLE);
  assign wr_fire  = bus.wr_valid && bus.wr_ready;
  assign pop      = bus.rd_valid && bus.rd_ready;
  assign occ      = {1'b0, cnt} + {2'b00, inflight};

  // An entry leaving this cycle frees its slot, which is what sustains
  // one beat per cycle with only two entries of buffering.
  assign issue = (state == S_RD) && (remaining != '0) &&
                 ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.wr_ready  = (state == S_WR) && (remaining != '0);
    bus.ram_en    = wr_fire || issue;
    bus.ram_wen   = wr_fire;
    bus.ram_addr  = bus.ram_en ? cur_addr : '0;
    bus.ram_wdata = wr_fire ? bus.wr_data : '0;
    bus.rd_valid  = (cnt != 2'd0);
    bus.rd_data   = bus.rd_valid ? fifo[rptr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pop_left  <= '0;
      fifo      <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      cnt       <= 2'd0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      // RAM read latency is fixed at one cycle, so capture is unconditional
      if (inflight) begin
        fifo[wptr] <= bus.ram_rdata;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            pop_left  <= bus.cmd_len;
            if (bus.cmd_len == '0)  state <= S_DONE;
            else if (bus.cmd_write) state <= S_WR;
            else                    state <= S_RD;
          end
        end
        S_WR: begin
          if (wr_fire) begin
            cur_addr  <= cur_addr + AWIDTH'(1);
            remaining <= remaining - LWIDTH'(1);
            if (remaining == LWIDTH'(1)) state <= S_DONE;
          end
        end
        S_RD: begin
          if (issue) begin
            cur_addr  <= cur_addr + AWIDTH'(1);
            remaining <= remaining - LWIDTH'(1);
          end
          if (pop) begin
            pop_left <= pop_left - LWIDTH'(1);
            if (pop_left == LWIDTH'(1)) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
